// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet frame parser.
package eth_pkg;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_e;

  localparam int          ETH_HDR_LEN    = 14;
  localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry data+last register with ready/valid on both sides; full throughput
// because it can load while its current entry is being taken.
module axis_reg_slice (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  input  logic       i_ready
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;

  assign o_ready = !valid_q || i_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

  // next entry state: load on input transfer, empty on output transfer
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (i_valid && o_ready) begin
      valid_d = 1'b1;
      data_d  = i_data;
      last_d  = i_last;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // entry register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/eth_frame_parser.sv
// Parses the 14-byte MAC header of an incoming byte stream, filters on
// destination MAC and EtherType, and forwards accepted payload bytes.
module eth_frame_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC        = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BROADCAST = 1'b1,
  parameter bit          PROMISCUOUS      = 1'b0,
  parameter logic [15:0] ETHERTYPE_FILTER = 16'h0000,
  parameter int          CNT_W            = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_eth_rx_valid,
  input  logic [7:0]       i_eth_rx_data,
  input  logic             i_eth_rx_last,
  output logic             o_eth_rx_ready,
  output logic             o_payload_valid,
  output logic [7:0]       o_payload_data,
  output logic             o_payload_last,
  input  logic             i_payload_ready,
  output logic             o_hdr_valid,
  output logic [47:0]      o_dst_mac,
  output logic [47:0]      o_src_mac,
  output logic [15:0]      o_ethertype,
  output logic [CNT_W-1:0] o_frames_ok,
  output logic [CNT_W-1:0] o_frames_dropped
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [111:0]       shd_q, shd_d;
  logic [47:0]        dst_q, dst_d, src_q, src_d;
  logic [15:0]        type_q, type_d;
  logic               hdr_valid_q, hdr_valid_d;
  logic [CNT_W-1:0]   ok_q, ok_d, drop_q, drop_d;
  logic               run_q;

  logic         slice_ready, slice_valid, in_xfer;
  logic [111:0] shd_next;
  logic         mac_ok, type_ok;

  // ready is held low until the first cycle after reset release
  assign o_eth_rx_ready = run_q && ((state_q == PAYLOAD) ? slice_ready : 1'b1);
  assign in_xfer        = i_eth_rx_valid && o_eth_rx_ready;
  assign slice_valid    = i_eth_rx_valid && run_q && (state_q == PAYLOAD);

  assign shd_next = {shd_q[103:0], i_eth_rx_data};
  assign mac_ok   = PROMISCUOUS || (shd_next[111:64] == LOCAL_MAC) ||
                    (ACCEPT_BROADCAST && (shd_next[111:64] == BROADCAST_MAC));
  assign type_ok  = (ETHERTYPE_FILTER == 16'h0000) || (shd_next[15:0] == ETHERTYPE_FILTER);

  assign o_hdr_valid      = hdr_valid_q;
  assign o_dst_mac        = dst_q;
  assign o_src_mac        = src_q;
  assign o_ethertype      = type_q;
  assign o_frames_ok      = ok_q;
  assign o_frames_dropped = drop_q;

  axis_reg_slice u_out (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (slice_valid),
    .i_data  (i_eth_rx_data),
    .i_last  (i_eth_rx_last),
    .o_ready (slice_ready),
    .o_valid (o_payload_valid),
    .o_data  (o_payload_data),
    .o_last  (o_payload_last),
    .i_ready (i_payload_ready)
  );

  // frame FSM, header capture and statistics
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shd_d       = shd_q;
    dst_d       = dst_q;
    src_d       = src_q;
    type_d      = type_q;
    hdr_valid_d = 1'b0;
    ok_d        = ok_q;
    drop_d      = drop_q;
    case (state_q)
      HEADER: begin
        if (in_xfer) begin
          shd_d = shd_next;
          if (i_eth_rx_last) begin
            drop_d = sat_inc(drop_q);
            cnt_d  = 4'd0;
          end else if (cnt_q == 4'(ETH_HDR_LEN - 1)) begin
            cnt_d = 4'd0;
            if (mac_ok && type_ok) begin
              state_d     = PAYLOAD;
              hdr_valid_d = 1'b1;
              dst_d       = shd_next[111:64];
              src_d       = shd_next[63:16];
              type_d      = shd_next[15:0];
            end else begin
              state_d = DROP;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      PAYLOAD: begin
        if (in_xfer && i_eth_rx_last) begin
          ok_d    = sat_inc(ok_q);
          state_d = HEADER;
        end else begin
          state_d = PAYLOAD;
        end
      end
      DROP: begin
        if (in_xfer && i_eth_rx_last) begin
          drop_d  = sat_inc(drop_q);
          state_d = HEADER;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = HEADER;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= HEADER;
      cnt_q       <= 4'd0;
      shd_q       <= 112'd0;
      dst_q       <= 48'd0;
      src_q       <= 48'd0;
      type_q      <= 16'd0;
      hdr_valid_q <= 1'b0;
      ok_q        <= '0;
      drop_q      <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shd_q       <= shd_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      type_q      <= type_d;
      hdr_valid_q <= hdr_valid_d;
      ok_q        <= ok_d;
      drop_q      <= drop_d;
      run_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_frame_parser.sv
// Scoreboard bench for eth_frame_parser: default-parameter instance plus an
// instance filtering on the ARP EtherType.
module tb_eth_frame_parser;
  import eth_pkg::*;

  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SMAC = 48'h0A_0B_0C_0D_0E_0F;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic rst_n;
  logic tgl;

  logic        a_vld, a_last, a_rdy, a_pv, a_pl, a_pr, a_hv;
  logic [7:0]  a_dat, a_pd;
  logic [47:0] a_dst, a_src;
  logic [15:0] a_type, a_ok, a_drop;

  logic        b_vld, b_last, b_rdy, b_pv, b_pl, b_pr, b_hv;
  logic [7:0]  b_dat, b_pd;
  logic [47:0] b_dst, b_src;
  logic [15:0] b_type, b_ok, b_drop;

  eth_frame_parser u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_eth_rx_valid(a_vld), .i_eth_rx_data(a_dat), .i_eth_rx_last(a_last),
    .o_eth_rx_ready(a_rdy),
    .o_payload_valid(a_pv), .o_payload_data(a_pd), .o_payload_last(a_pl),
    .i_payload_ready(a_pr),
    .o_hdr_valid(a_hv), .o_dst_mac(a_dst), .o_src_mac(a_src), .o_ethertype(a_type),
    .o_frames_ok(a_ok), .o_frames_dropped(a_drop)
  );

  eth_frame_parser #(.ETHERTYPE_FILTER(16'h0806)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_eth_rx_valid(b_vld), .i_eth_rx_data(b_dat), .i_eth_rx_last(b_last),
    .o_eth_rx_ready(b_rdy),
    .o_payload_valid(b_pv), .o_payload_data(b_pd), .o_payload_last(b_pl),
    .i_payload_ready(b_pr),
    .o_hdr_valid(b_hv), .o_dst_mac(b_dst), .o_src_mac(b_src), .o_ethertype(b_type),
    .o_frames_ok(b_ok), .o_frames_dropped(b_drop)
  );

  logic [8:0]   exp_q[$];   // {last, data}
  logic [111:0] hexp_q[$];  // {dst, src, type}
  logic [7:0]   fr[$];
  int n_chk  = 0;
  int n_fail = 0;
  logic chk_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // monitor: pops the scoreboard on every payload transfer and header pulse
  logic       stall_seen = 1'b0;
  logic [8:0] stall_val;
  logic       hv_prev = 1'b0;
  logic [8:0] e;
  logic [111:0] he;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (stall_seen) begin
        n_chk++;
        if (!a_pv || {a_pl, a_pd} !== stall_val) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b %h want v=1 %h", a_pv, {a_pl, a_pd}, stall_val);
        end
      end
      stall_seen = a_pv && !a_pr;
      stall_val  = {a_pl, a_pd};
      if (a_pv && a_pr) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_payload: got %h want nothing", {a_pl, a_pd});
        end else begin
          e = exp_q.pop_front();
          if ({a_pl, a_pd} !== e) begin
            n_fail++;
            $display("FAIL payload: got %h want %h", {a_pl, a_pd}, e);
          end
        end
      end
      if (a_hv) begin
        n_chk++;
        if (hv_prev) begin
          n_fail++;
          $display("FAIL hdr_pulse: got 2-cycle pulse want 1");
        end else if (hexp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_hdr: got %h want nothing", {a_dst, a_src, a_type});
        end else begin
          he = hexp_q.pop_front();
          if ({a_dst, a_src, a_type} !== he) begin
            n_fail++;
            $display("FAIL hdr_fields: got %h want %h", {a_dst, a_src, a_type}, he);
          end
        end
      end
      hv_prev = a_hv;
      if (chk_rdy) begin
        n_chk++;
        if (a_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_ready: got %b want 1", a_rdy);
        end
      end
    end else begin
      stall_seen = 1'b0;
      hv_prev    = 1'b0;
    end
  end

  // downstream ready: constant 1 or toggling each cycle
  initial begin
    a_pr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_pr = tgl ? ~a_pr : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin
      a_vld = v; a_dat = d; a_last = l;
    end else begin
      b_vld = v; b_dat = d; b_last = l;
    end
  endtask

  task automatic send(input int sel, input logic with_last);
    int n;
    for (int i = 0; i < fr.size(); i++) begin
      drive(sel, 1'b1, fr[i], with_last && (i == fr.size() - 1));
      n = 0;
      @(negedge clk);
      while (((sel == 0) ? a_rdy : b_rdy) !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_ready_timeout: got ready=0 want 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] typ, input int npay,
                       input logic [7:0] base, input logic [7:0] step, input logic exp_pay);
    logic [111:0] h;
    logic [7:0]   b;
    h = {dst, SMAC, typ};
    fr.delete();
    for (int i = 0; i < 14; i++) fr.push_back(h[111 - 8 * i -: 8]);
    b = base;
    for (int i = 0; i < npay; i++) begin
      fr.push_back(b);
      if (exp_pay) exp_q.push_back({(i == npay - 1), b});
      b = b + step;
    end
    if (exp_pay) hexp_q.push_back(h);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tgl   = 1'b0;
    b_pr  = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    idle(3);
    chk("reset_ready", 64'(a_rdy), 64'd0);
    chk("reset_pvalid", 64'({a_pv, a_pl, a_pd, a_hv}), 64'd0);
    chk("reset_hdr", 64'(a_dst | a_src | 48'(a_type)), 64'd0);
    chk("reset_cnt", 64'({a_ok, a_drop}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // unicast IPv4, payload AA BB CC DD
    build(LMAC, ETHERTYPE_IPV4, 4, 8'hAA, 8'h11, 1'b1);
    send(0, 1'b1);
    idle(4);
    chk("a_ok", 64'(a_ok), 64'd1);
    chk("a_drop", 64'(a_drop), 64'd0);
    chk("a_type_hold", 64'(a_type), 64'h0800);

    // wrong destination is dropped with ready held high
    chk_rdy = 1'b1;
    build(48'h02_00_00_00_00_99, ETHERTYPE_IPV4, 6, 8'h50, 8'h01, 1'b0);
    send(0, 1'b1);
    idle(2);
    chk_rdy = 1'b0;
    idle(2);
    chk("b_ok", 64'(a_ok), 64'd1);
    chk("b_drop", 64'(a_drop), 64'd1);

    // broadcast with toggling downstream ready
    tgl = 1'b1;
    build(BROADCAST_MAC, 16'h88B5, 10, 8'h10, 8'h01, 1'b1);
    send(0, 1'b1);
    idle(10);
    tgl = 1'b0;
    idle(2);
    chk("bc_ok", 64'(a_ok), 64'd2);
    chk("bc_drop", 64'(a_drop), 64'd1);

    // runt ending on byte 9, then a good ARP frame straight after
    build(LMAC, ETHERTYPE_IPV4, 0, 8'h00, 8'h00, 1'b0);
    while (fr.size() > 10) void'(fr.pop_back());
    send(0, 1'b1);
    build(LMAC, ETHERTYPE_ARP, 3, 8'h01, 8'h01, 1'b1);
    send(0, 1'b1);
    idle(4);
    chk("runt_ok", 64'(a_ok), 64'd3);
    chk("runt_drop", 64'(a_drop), 64'd2);

    // header-only frame is a runt
    build(LMAC, ETHERTYPE_IPV4, 0, 8'h00, 8'h00, 1'b0);
    send(0, 1'b1);
    idle(3);
    chk("hdr_only_drop", 64'(a_drop), 64'd3);
    chk("hdr_only_ok", 64'(a_ok), 64'd3);

    // ARP filter instance: ARP accepted, IPv4 dropped
    build(LMAC, ETHERTYPE_ARP, 2, 8'h77, 8'h01, 1'b0);
    send(1, 1'b1);
    build(LMAC, ETHERTYPE_IPV4, 2, 8'h66, 8'h01, 1'b0);
    send(1, 1'b1);
    idle(4);
    chk("arp_ok", 64'(b_ok), 64'd1);
    chk("arp_drop", 64'(b_drop), 64'd1);
    chk("arp_type", 64'(b_type), 64'h0806);

    // reset asserted while payload byte 3 is offered
    build(LMAC, ETHERTYPE_IPV4, 8, 8'hE0, 8'h01, 1'b1);
    while (fr.size() > 17) void'(fr.pop_back());
    send(0, 1'b0);
    drive(0, 1'b1, 8'hE3, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(a_rdy), 64'd0);
    chk("mid_rst_pay", 64'({a_pv, a_pl, a_pd, a_hv}), 64'd0);
    chk("mid_rst_hdr", 64'(a_dst | a_src | 48'(a_type)), 64'd0);
    chk("mid_rst_cnt", 64'({a_ok, a_drop}), 64'd0);
    chk("mid_rst_delivered", 64'(exp_q.size()), 64'd5);
    exp_q.delete();
    hexp_q.delete();
    drive(0, 1'b0, 8'h00, 1'b0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    build(LMAC, ETHERTYPE_IPV4, 3, 8'hC0, 8'h01, 1'b1);
    send(0, 1'b1);
    idle(4);
    chk("post_rst_ok", 64'(a_ok), 64'd1);
    chk("post_rst_drop", 64'(a_drop), 64'd0);

    chk("pay_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("hdr_queue_empty", 64'(hexp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_frame_parser.md
Name: eth_frame_parser

Overview:
Consumes the raw Ethernet frame byte stream produced by ethernet_connection (o_eth_rx_valid/data/last, i_eth_rx_ready) and parses the 14-byte MAC header.
Filters each frame on destination MAC and EtherType, then forwards accepted payload bytes as a downstream stream with its own ready/valid handshake.
Publishes the parsed header fields and saturating frame statistics.
Sits between ethernet_connection and the application payload consumer in the 125 MHz Ethernet clock domain.

Parameters:
LOCAL_MAC, 48'h02_00_00_00_00_01, station MAC address accepted as destination.
ACCEPT_BROADCAST, 1, when 1 also accept dst FF:FF:FF:FF:FF:FF.
PROMISCUOUS, 0, when 1 accept any destination MAC.
ETHERTYPE_FILTER, 16'h0000, accepted EtherType; 0 means accept any.
CNT_W, 16, width of the statistics counters.

Ports:
i_clk  in  1  125 MHz Ethernet clock.
i_rst_n  in  1  asynchronous active-low reset.
i_eth_rx_valid  in  1  input byte valid.
i_eth_rx_data  in  8  input byte; frame starts at first dst MAC byte; preamble, SFD and FCS already removed upstream.
i_eth_rx_last  in  1  marks the final byte of the frame.
o_eth_rx_ready  out  1  input ready.
o_payload_valid  out  1  payload byte valid.
o_payload_data  out  8  payload byte.
o_payload_last  out  1  marks the final payload byte.
i_payload_ready  in  1  downstream ready.
o_hdr_valid  out  1  one-cycle pulse when an accepted header completes.
o_dst_mac  out  48  destination MAC of the last accepted frame.
o_src_mac  out  48  source MAC of the last accepted frame.
o_ethertype  out  16  EtherType of the last accepted frame.
o_frames_ok  out  CNT_W  accepted frames, saturating.
o_frames_dropped  out  CNT_W  filtered and runt frames, saturating.

Behaviour:
- Reset values (asynchronous, i_rst_n=0): every output 0; state HEADER; byte counter 0; output register empty.
- A byte transfers on input when i_eth_rx_valid && o_eth_rx_ready, and on output when o_payload_valid && i_payload_ready.
- HEADER:
  - o_eth_rx_ready=1.
  - 4-bit counter 0..13; byte n shifts into a dst/src/type shadow register, big-endian, byte 0 = MSB of dst.
  - last on byte 0..13 -> runt: dropped++, counter=0, stay HEADER. A header with zero payload is therefore a runt.
  - Byte 13 accepted without last:
    - If match -> PAYLOAD. Next cycle: o_hdr_valid=1 for exactly one cycle, and o_dst_mac, o_src_mac, o_ethertype update from the shadow registers and hold until the next accepted header.
    - Else -> DROP.
  - Match rule: (PROMISCUOUS || dst==LOCAL_MAC || (ACCEPT_BROADCAST && dst==48'hFFFFFFFFFFFF)) && (ETHERTYPE_FILTER==0 || type==ETHERTYPE_FILTER).
- PAYLOAD:
  - One-entry output register; o_eth_rx_ready = !o_payload_valid || i_payload_ready.
  - An accepted input byte appears on the output the cycle after acceptance, with last copied.
  - Full throughput of 1 byte/cycle while i_payload_ready=1.
  - Input byte with last accepted -> frames_ok++, counter=0, HEADER. The output register may still hold that last byte and drains normally while the next header is parsed.
- DROP: o_eth_rx_ready=1; bytes discarded; on last -> dropped++, HEADER.
- Output register state is independent of the FSM state.
- Counters saturate at all-ones and never wrap.
- Simultaneous ok and dropped increments cannot occur because there is one frame end per cycle.
- i_eth_rx_data is ignored when valid=0.
- Reset asserted mid-frame: everything clears immediately. After release the parser treats the next valid byte as byte 0 of a header. Upstream is responsible for restarting on a frame boundary.
- o_payload_data/last hold stable while o_payload_valid && !i_payload_ready.

Decomposition:
- Shared package eth_pkg:
  - state enum HEADER/PAYLOAD/DROP;
  - ETH_HDR_LEN=14;
  - BROADCAST_MAC constant;
  - EtherType constants (IPV4 16'h0800, ARP 16'h0806).
- One natural sub-module: axis_reg_slice, an 8-bit data + last one-entry register used for the payload output.
- Header shift register, filter compare and counters live in the top.

Test Plan:
- Frame dst=LOCAL_MAC, type 0x0800, 4 payload bytes AA BB CC DD, i_payload_ready=1 -> output AA BB CC DD with last on DD; o_hdr_valid one pulse with o_ethertype=16'h0800; frames_ok=1.
- Frame dst=02:00:00:00:00:99, PROMISCUOUS=0 -> no o_payload_valid, no o_hdr_valid; frames_dropped=1; o_eth_rx_ready stays 1 throughout.
- Broadcast dst with 10 payload bytes, i_payload_ready toggled 1/0 each cycle -> all 10 bytes delivered in order; data held stable while stalled; no loss or duplication.
- Runt: last asserted on byte 9 -> frames_dropped=1; the immediately following valid frame parses correctly, frames_ok=1.
- ETHERTYPE_FILTER=16'h0806: ARP frame accepted and IPv4 frame dropped -> frames_ok=1, frames_dropped=1.
- i_rst_n pulsed low at payload byte 3 of a frame -> all outputs 0 immediately; a clean frame sent after release is accepted; counters read ok=1, dropped=0.
